gray_word_packer: RTL and testbench
===================================

Name: gray_word_packer

Overview:
- Sits directly downstream of the RGB565-to-grayscale converter in the camera path.
- Collects the 8-bit grayscale pixel stream, four pixels at a time, into 32-bit words.
- Buffers completed words in a small show-ahead FIFO, which a DMA/bus-master writer drains through a valid/ready handshake.
- The camera side cannot stall, so the block has no input backpressure. Overflow is detected and flagged.

Parameters:
- FIFO_DEPTH, 8, number of 32-bit words buffered; must be a power of two and at least 2.
- FIFO_AW, $clog2(FIFO_DEPTH), derived FIFO address width; not to be overridden.

Ports:
- clock  in  1  system clock; all logic is rising-edge.
- nReset  in  1  asynchronous, active-low reset.
- frameStart  in  1  single-cycle pulse marking the first pixel of a frame.
- grayValid  in  1  grayData is valid this cycle.
- grayData  in  8  grayscale pixel.
- wordReady  in  1  consumer accepts wordData this cycle.
- wordValid  out  1  FIFO head is valid.
- wordData  out  32  FIFO head word.
- fifoLevel  out  FIFO_AW+1  number of words currently stored.
- overflow  out  1  sticky: a completed word was dropped.

Behaviour:
- Reset and interface:
  - One clock domain; reset is asynchronous and active-low.
  - Reset (nReset=0) clears the following immediately, independent of clock: lane counter to 0, partial word to 0, FIFO pointers to 0, wordValid to 0, wordData to 0, fifoLevel to 0, overflow to 0.
  - Reset asserted mid-word or mid-transfer discards everything. No partial word survives.
- Lane counter:
  - 2 bits, values 0..3.
  - On each cycle with grayValid=1, grayData is written into lane (lane counter) and the counter increments, wrapping from 3 to 0.
  - Default byte order: the lane-0 pixel goes to bits [7:0] and the lane-3 pixel to bits [31:24], i.e. little-endian.
- Push:
  - A push occurs on the clock edge where grayValid=1 and the lane counter is 3.
  - The pushed word is the three stored bytes plus the current grayData. It is assembled combinationally, so no extra cycle is spent.
- Latency:
  - If the FIFO was empty, wordValid rises in the cycle after the push edge, with wordData equal to the pushed word.
  - End to end, the fourth pixel reaches wordValid 1 cycle later.
- Output handshake:
  - A pop occurs when wordValid=1 and wordReady=1. The FIFO is show-ahead, so the next word or wordValid=0 appears the following cycle.
  - While wordValid=1 and wordReady=0, wordData must hold stable.
  - wordReady while the FIFO is empty has no effect.
- Full FIFO:
  - Push with the FIFO full and no pop in the same cycle: the word is dropped, fifoLevel stays at FIFO_DEPTH, and overflow is set on that edge.
  - Push and pop in the same cycle with the FIFO full: both succeed and the level is unchanged.
  - Push and pop in the same cycle with the FIFO empty: impossible, because wordValid is 0.
- fifoLevel:
  - +1 on push only, −1 on pop only, unchanged on both or neither.
  - Never exceeds FIFO_DEPTH and never wraps below 0.
- frameStart:
  - Resets the lane counter, discarding any partial word, and clears overflow.
  - If grayValid=1 in the same cycle, that pixel is stored as lane 0 of the new frame.
  - Completed words already in the FIFO are kept and drained normally.
  - If frameStart and an overflow event occur in the same cycle: frameStart with grayValid cannot produce a push because the lane is forced to 0. frameStart therefore wins and overflow ends at 0.
- grayValid=0 cycles: no state change in the packing logic.

Optional Feature:
- Macro: GRAY_PACKER_BIG_ENDIAN_EN.
- Defined: the lane-0 pixel goes to bits [31:24] and the lane-3 pixel to bits [7:0], for big-endian bus masters.
- Undefined: little-endian mapping as above.
- Only the lane-to-bit mapping changes. Latency, handshake and the FIFO are identical in both cases.

Decomposition:
- Shared package gray_packer_pkg holds:
  - constants PIX_W=8, WORD_W=32, LANES=4, LANE_W=2;
  - typedef pix_t (PIX_W bits);
  - typedef word_t (WORD_W bits);
  - typedef lane_t (LANE_W bits).
- One natural sub-module: gray_word_fifo.
  - Synchronous single-clock show-ahead FIFO, parameterised by depth.
  - Ports: push/din/full, pop/dout/empty, level.
  - Contains the overflow-free pointer logic.
- The packing logic, lane counter and overflow flag stay in the top level.

Test Plan:
- Reset then 4 pixels 0x11,0x22,0x33,0x44 on consecutive cycles, wordReady=1 → wordData=0x44332211 with wordValid=1 for exactly 1 cycle, 1 cycle after the 4th pixel; with the macro defined, wordData=0x11223344.
- 2 pixels 0xAA,0xBB, then frameStart with pixel 0x01, then 0x02,0x03,0x04 → exactly one word, 0x04030201; no word contains 0xAA or 0xBB.
- wordReady=0, 4×FIFO_DEPTH pixels pushed (8 words, values 0..31) → fifoLevel=8 and overflow=0. Then 4 more pixels → fifoLevel stays 8 and overflow=1. Draining then yields the first 8 words in order.
- FIFO full, wordReady=1 held in the same cycle as a push → no overflow; fifoLevel stays 8; the output sequence is continuous with no lost words.
- wordValid=1 with wordReady toggled 0,0,1 → wordData is stable across the stalled cycles and advances only after the pop.
- nReset asserted asynchronously between clock edges with 3 words queued and a partial word pending → outputs are 0 immediately. After release, the next 4 pixels form a fresh word.

Source files
------------

// File: rtl/gray_packer_pkg.sv
// Shared types and constants for the grayscale word packer.
// Holds the lane-placement helper used by the packing logic.
package gray_packer_pkg;

  localparam int PIX_W  = 8;
  localparam int WORD_W = 32;
  localparam int LANES  = 4;
  localparam int LANE_W = 2;

  typedef logic [PIX_W-1:0]  pix_t;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [LANE_W-1:0] lane_t;

  // Returns w with pixel p written into the byte slot that belongs to lane.
  // Big-endian mode mirrors the slot order (lane 0 lands in the top byte).
  function automatic word_t place_pix(word_t w, lane_t lane, pix_t p, bit big_endian);
    lane_t slot;
    word_t r;
    slot = big_endian ? ~lane : lane;
    r = w;
    r[slot*PIX_W +: PIX_W] = p;
    return r;
  endfunction

endpackage

// File: rtl/gray_word_fifo.sv
// Single-clock show-ahead FIFO for packed words; the head is visible on dout
// whenever empty is low. Pushes into a full FIFO are ignored unless a pop frees a slot.
module gray_word_fifo
  import gray_packer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  word_t       din,
  output logic        full,
  input  logic        pop,
  output word_t       dout,
  output logic        empty,
  output logic [AW:0] level
);

  // One extra pointer bit distinguishes full from empty without a separate counter.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  word_t       mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update tied to the same edge.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Gating the head with empty makes the output read zero after reset.
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/gray_word_packer.sv
// Packs the 8-bit grayscale pixel stream four at a time into 32-bit words and queues them.
// Define GRAY_PACKER_BIG_ENDIAN_EN to put lane 0 in bits [31:24] instead of [7:0].
module gray_word_packer
  import gray_packer_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
  input  logic               clock,
  input  logic               nReset,
  input  logic               frameStart,
  input  logic               grayValid,
  input  logic [7:0]         grayData,
  input  logic               wordReady,
  output logic               wordValid,
  output logic [31:0]        wordData,
  output logic [FIFO_AW:0]   fifoLevel,
  output logic               overflow
);

`ifdef GRAY_PACKER_BIG_ENDIAN_EN
  localparam bit BIG_ENDIAN = 1'b1;
`else
  localparam bit BIG_ENDIAN = 1'b0;
`endif

  lane_t lane;
  word_t partial;
  word_t push_word;
  logic  push_req;
  logic  fifo_full;
  logic  fifo_empty;

  // The completed word is assembled combinationally so the fourth pixel pushes on its own edge.
  assign push_word = place_pix(partial, lane, grayData, BIG_ENDIAN);
  assign push_req  = grayValid && !frameStart && (lane == lane_t'(LANES-1));

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      lane    <= '0;
      partial <= '0;
    end else if (frameStart) begin
      // A frame start restarts packing; a coincident pixel becomes lane 0 of the new frame.
      lane    <= grayValid ? lane_t'(1) : '0;
      partial <= grayValid ? place_pix('0, '0, grayData, BIG_ENDIAN) : '0;
    end else if (grayValid) begin
      lane    <= lane + 1'b1;
      partial <= push_word;
    end
  end

  // A full FIFO can only accept a word when the consumer pops in the same cycle.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      overflow <= 1'b0;
    end else if (frameStart) begin
      overflow <= 1'b0;
    end else if (push_req && fifo_full && !wordReady) begin
      overflow <= 1'b1;
    end
  end

  gray_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clock),
    .rst_n (nReset),
    .push  (push_req),
    .din   (push_word),
    .full  (fifo_full),
    .pop   (wordReady),
    .dout  (wordData),
    .empty (fifo_empty),
    .level (fifoLevel)
  );

  assign wordValid = !fifo_empty;

endmodule

// File: tb/tb_gray_word_packer.sv
// Directed self-checking bench for gray_word_packer with hand-computed expected words.
// Honors GRAY_PACKER_BIG_ENDIAN_EN when building expected byte order.
module tb_gray_word_packer;

  localparam int DEPTH = 8;

  logic        clock      = 1'b0;
  logic        nReset     = 1'b0;
  logic        frameStart = 1'b0;
  logic        grayValid  = 1'b0;
  logic [7:0]  grayData   = 8'h00;
  logic        wordReady  = 1'b0;
  logic        wordValid;
  logic [31:0] wordData;
  logic [3:0]  fifoLevel;
  logic        overflow;

  int n_total = 0;
  int n_bad   = 0;

  gray_word_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .clock      (clock),
    .nReset     (nReset),
    .frameStart (frameStart),
    .grayValid  (grayValid),
    .grayData   (grayData),
    .wordReady  (wordReady),
    .wordValid  (wordValid),
    .wordData   (wordData),
    .fifoLevel  (fifoLevel),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Expected word from four pixels in arrival order.
  function automatic logic [31:0] pack(input logic [7:0] b0, b1, b2, b3);
`ifdef GRAY_PACKER_BIG_ENDIAN_EN
    return {b0, b1, b2, b3};
`else
    return {b3, b2, b1, b0};
`endif
  endfunction

  function automatic logic [31:0] pack_seq(input logic [7:0] first);
    return pack(first, first + 8'd1, first + 8'd2, first + 8'd3);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_pix(input logic [7:0] d);
    grayValid = 1'b1;
    grayData  = d;
    tick();
    grayValid = 1'b0;
  endtask

  task automatic fill_words(input logic [7:0] base, input int n);
    for (int i = 0; i < 4*n; i++) send_pix(base + 8'(i));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_valid", 32'(wordValid), 32'd0);
    check("rst_data",  wordData,       32'd0);
    check("rst_level", 32'(fifoLevel), 32'd0);
    check("rst_ovf",   32'(overflow),  32'd0);
    nReset = 1'b1;
    tick();

    // Basic packing and one-cycle latency
    wordReady = 1'b1;
    send_pix(8'h11);
    check("t1_valid_p1", 32'(wordValid), 32'd0);
    send_pix(8'h22);
    send_pix(8'h33);
    check("t1_valid_p3", 32'(wordValid), 32'd0);
    send_pix(8'h44);
    check("t1_valid", 32'(wordValid), 32'd1);
    check("t1_data",  wordData,       pack(8'h11, 8'h22, 8'h33, 8'h44));
    tick();
    check("t1_valid_after", 32'(wordValid), 32'd0);

    // frameStart discards the partial word
    send_pix(8'hAA);
    send_pix(8'hBB);
    frameStart = 1'b1;
    send_pix(8'h01);
    frameStart = 1'b0;
    check("t2_ovf_clr", 32'(overflow), 32'd0);
    send_pix(8'h02);
    send_pix(8'h03);
    check("t2_no_word", 32'(wordValid), 32'd0);
    send_pix(8'h04);
    check("t2_valid", 32'(wordValid), 32'd1);
    check("t2_data",  wordData,       pack(8'h01, 8'h02, 8'h03, 8'h04));
    tick();
    check("t2_single", 32'(wordValid), 32'd0);

    // Fill, overflow, drain
    wordReady = 1'b0;
    fill_words(8'h00, DEPTH);
    check("t3_level_full", 32'(fifoLevel), 32'd8);
    check("t3_ovf_before", 32'(overflow),  32'd0);
    fill_words(8'h20, 1);
    check("t3_level_stay", 32'(fifoLevel), 32'd8);
    check("t3_ovf_set",    32'(overflow),  32'd1);
    wordReady = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      check($sformatf("t3_drain_v%0d", k), 32'(wordValid), 32'd1);
      check($sformatf("t3_drain_d%0d", k), wordData, pack_seq(8'(4*k)));
      tick();
    end
    check("t3_empty", 32'(wordValid), 32'd0);
    check("t3_level0", 32'(fifoLevel), 32'd0);
    check("t3_ovf_sticky", 32'(overflow), 32'd1);

    // Push and pop together while full
    wordReady  = 1'b0;
    frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
    check("t4_ovf_clr", 32'(overflow), 32'd0);
    fill_words(8'h40, DEPTH);
    send_pix(8'h60);
    send_pix(8'h61);
    send_pix(8'h62);
    check("t4_level_full", 32'(fifoLevel), 32'd8);
    grayValid = 1'b1;
    grayData  = 8'h63;
    wordReady = 1'b1;
    check("t4_head", wordData, pack_seq(8'h40));
    tick();
    grayValid = 1'b0;
    check("t4_level_same", 32'(fifoLevel), 32'd8);
    check("t4_no_ovf",     32'(overflow),  32'd0);
    for (int k = 1; k <= DEPTH; k++) begin
      check($sformatf("t4_drain_v%0d", k), 32'(wordValid), 32'd1);
      check($sformatf("t4_drain_d%0d", k), wordData, pack_seq(8'h40 + 8'(4*k)));
      tick();
    end
    check("t4_empty", 32'(wordValid), 32'd0);

    // Stall holds the head stable
    wordReady = 1'b0;
    fill_words(8'h80, 2);
    check("t5_head0", wordData, pack_seq(8'h80));
    tick();
    check("t5_stall1_v", 32'(wordValid), 32'd1);
    check("t5_stall1_d", wordData, pack_seq(8'h80));
    tick();
    check("t5_stall2_d", wordData, pack_seq(8'h80));
    wordReady = 1'b1;
    tick();
    check("t5_adv_v", 32'(wordValid), 32'd1);
    check("t5_adv_d", wordData, pack_seq(8'h84));
    tick();
    check("t5_empty", 32'(wordValid), 32'd0);

    // Asynchronous reset mid-transfer
    wordReady = 1'b0;
    fill_words(8'hC0, DEPTH);
    fill_words(8'hE0, 1);
    check("t6_ovf_set", 32'(overflow), 32'd1);
    wordReady = 1'b1;
    repeat (5) tick();
    wordReady = 1'b0;
    check("t6_level3", 32'(fifoLevel), 32'd3);
    send_pix(8'hF0);
    send_pix(8'hF1);
    #3;
    nReset = 1'b0;
    #1;
    check("t6_rst_valid", 32'(wordValid), 32'd0);
    check("t6_rst_data",  wordData,       32'd0);
    check("t6_rst_level", 32'(fifoLevel), 32'd0);
    check("t6_rst_ovf",   32'(overflow),  32'd0);
    @(posedge clock);
    #3;
    nReset = 1'b1;
    tick();
    wordReady = 1'b1;
    send_pix(8'hA1);
    send_pix(8'hA2);
    send_pix(8'hA3);
    check("t6_no_early", 32'(wordValid), 32'd0);
    send_pix(8'hA4);
    check("t6_fresh_v", 32'(wordValid), 32'd1);
    check("t6_fresh_d", wordData, pack(8'hA1, 8'hA2, 8'hA3, 8'hA4));
    check("t6_level1",  32'(fifoLevel), 32'd1);
    tick();
    check("t6_empty", 32'(wordValid), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
